// File: rtl/gshare_predictor.sv
// gshare_predictor
// ----------------
// Front-end conditional-branch predictor. A pattern history table (PHT) of
// 2-bit saturating counters is indexed by PC xor speculative global history;
// a direct-mapped branch target buffer (BTB) supplies hit and target.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   fetch_valid         fetch presents fetch_pc this cycle
//   fetch_fire          fetch consumes the prediction (speculative history shift)
//   fetch_pc            PC being fetched
//   pred_valid          BTB hit for fetch_pc (gated by fetch_valid)
//   pred_taken          predicted direction (only with pred_valid)
//   pred_target         BTB target on hit, else 0
//   pred_index          PHT index used, carried to the ROB (0 without fetch_valid)
//   commit_valid        ROB commits a conditional branch
//   commit_pred_valid   committed branch had a BTB hit at fetch
//   commit_index        PHT index recorded at fetch
//   commit_taken        resolved direction
//   commit_pc           branch PC
//   commit_target       resolved taken target
//   flush               ROB-head mispredict flush; repairs speculative history
//
// Prediction outputs are combinational (zero-cycle latency); every state
// update lands on the next rising clk, so a same-cycle lookup sees old state.

module gshare_predictor #(
    parameter int HISTORY_BITS = 8,
    parameter int BTB_ENTRIES  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    fetch_valid,
    input  logic                    fetch_fire,
    input  logic [31:0]             fetch_pc,
    output logic                    pred_valid,
    output logic                    pred_taken,
    output logic [31:0]             pred_target,
    output logic [HISTORY_BITS-1:0] pred_index,
    input  logic                    commit_valid,
    input  logic                    commit_pred_valid,
    input  logic [HISTORY_BITS-1:0] commit_index,
    input  logic                    commit_taken,
    input  logic [31:0]             commit_pc,
    input  logic [31:0]             commit_target,
    input  logic                    flush
);

    localparam int BI          = $clog2(BTB_ENTRIES);
    localparam int PHT_ENTRIES = 1 << HISTORY_BITS;
    localparam int TAG_W       = 32 - BI - 2;

    // Saturating 2-bit counter step: up on taken, down on not-taken.
    function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        if (taken) begin
            if (ctr == 2'b11) res = ctr;
            else              res = ctr + 2'b01;
        end else begin
            if (ctr == 2'b00) res = ctr;
            else              res = ctr - 2'b01;
        end
        return res;
    endfunction

    logic [1:0]              pht_r        [PHT_ENTRIES];
    logic [BTB_ENTRIES-1:0]  btb_valid_r;
    logic [TAG_W-1:0]        btb_tag_r    [BTB_ENTRIES];
    logic [31:0]             btb_target_r [BTB_ENTRIES];
    logic [HISTORY_BITS-1:0] spec_ghr_r;
    logic [HISTORY_BITS-1:0] arch_ghr_r;

    logic [HISTORY_BITS-1:0] idx_s;
    logic [BI-1:0]           fetch_set_s;
    logic [TAG_W-1:0]        fetch_tag_s;
    logic                    hit_s;
    logic [1:0]              ctr_s;
    logic [HISTORY_BITS-1:0] arch_next_s;
    logic [BI-1:0]           commit_set_s;
    logic [TAG_W-1:0]        commit_tag_s;
    logic                    unused_s;

    // The two low PC bits never take part in indexing or tagging.
    assign unused_s     = ^{fetch_pc[1:0], commit_pc[1:0]};
    assign commit_set_s = commit_pc[BI+1:2];
    assign commit_tag_s = commit_pc[31:BI+2];

    // Table lookup for the fetched PC against current (pre-update) state.
    always_comb begin
        fetch_set_s = fetch_pc[BI+1:2];
        fetch_tag_s = fetch_pc[31:BI+2];
        idx_s       = fetch_pc[HISTORY_BITS+1:2] ^ spec_ghr_r;
        hit_s       = btb_valid_r[fetch_set_s] && (btb_tag_r[fetch_set_s] == fetch_tag_s);
        ctr_s       = pht_r[idx_s];
    end

    // Prediction outputs; target is reported on any hit, even without fetch_valid.
    always_comb begin
        pred_valid  = 1'b0;
        pred_taken  = 1'b0;
        pred_target = 32'h0000_0000;
        pred_index  = {HISTORY_BITS{1'b0}};
        if (fetch_valid) begin
            pred_valid = hit_s;
            pred_taken = hit_s & ctr_s[1];
            pred_index = idx_s;
        end else begin
            pred_valid = 1'b0;
            pred_taken = 1'b0;
            pred_index = {HISTORY_BITS{1'b0}};
        end
        if (hit_s) begin
            pred_target = btb_target_r[fetch_set_s];
        end else begin
            pred_target = 32'h0000_0000;
        end
    end

    // Architectural history only advances for branches that were predicted.
    always_comb begin
        arch_next_s = arch_ghr_r;
        if (commit_valid && commit_pred_valid) begin
            arch_next_s = {arch_ghr_r[HISTORY_BITS-2:0], commit_taken};
        end else begin
            arch_next_s = arch_ghr_r;
        end
    end

    // Global history registers; flush repair overrides a same-cycle fetch shift.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spec_ghr_r <= {HISTORY_BITS{1'b0}};
            arch_ghr_r <= {HISTORY_BITS{1'b0}};
        end else begin
            arch_ghr_r <= arch_next_s;
            if (flush) begin
                spec_ghr_r <= arch_next_s;
            end else if (fetch_fire && pred_valid) begin
                spec_ghr_r <= {spec_ghr_r[HISTORY_BITS-2:0], pred_taken};
            end else begin
                spec_ghr_r <= spec_ghr_r;
            end
        end
    end

    // PHT training on every commit, independent of flush and prior hit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PHT_ENTRIES; i++) begin
                pht_r[i] <= 2'b01;
            end
        end else if (commit_valid) begin
            pht_r[commit_index] <= sat_update(pht_r[commit_index], commit_taken);
        end else begin
            pht_r[commit_index] <= pht_r[commit_index];
        end
    end

    // BTB allocation/overwrite on taken commits only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btb_valid_r <= {BTB_ENTRIES{1'b0}};
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb_tag_r[i]    <= {TAG_W{1'b0}};
                btb_target_r[i] <= 32'h0000_0000;
            end
        end else if (commit_valid && commit_taken) begin
            btb_valid_r[commit_set_s]  <= 1'b1;
            btb_tag_r[commit_set_s]    <= commit_tag_s;
            btb_target_r[commit_set_s] <= commit_target;
        end else begin
            btb_valid_r <= btb_valid_r;
        end
    end

endmodule

// File: tb/tb_gshare_predictor.sv
// Testbench for gshare_predictor: directed steps following the block's
// intended behaviour, then a randomized run compared against a reference
// model built from integer arithmetic over plain arrays.

module tb_gshare_predictor;

    localparam int H  = 8;
    localparam int NB = 16;
    localparam int BI = 4;
    localparam int NP = 256;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          fetch_valid, fetch_fire;
    logic [31:0]   fetch_pc;
    logic          pred_valid, pred_taken;
    logic [31:0]   pred_target;
    logic [H-1:0]  pred_index;
    logic          commit_valid, commit_pred_valid, commit_taken, flush;
    logic [H-1:0]  commit_index;
    logic [31:0]   commit_pc, commit_target;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int          m_pht [NP];
    bit          m_bv  [NB];
    int unsigned m_tag [NB];
    int unsigned m_tgt [NB];
    int unsigned m_spec, m_arch;

    gshare_predictor #(.HISTORY_BITS(H), .BTB_ENTRIES(NB)) dut (
        .clk(clk), .rst(rst),
        .fetch_valid(fetch_valid), .fetch_fire(fetch_fire), .fetch_pc(fetch_pc),
        .pred_valid(pred_valid), .pred_taken(pred_taken),
        .pred_target(pred_target), .pred_index(pred_index),
        .commit_valid(commit_valid), .commit_pred_valid(commit_pred_valid),
        .commit_index(commit_index), .commit_taken(commit_taken),
        .commit_pc(commit_pc), .commit_target(commit_target), .flush(flush)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < NP; i++) m_pht[i] = 1;
        for (int i = 0; i < NB; i++) begin
            m_bv[i] = 1'b0; m_tag[i] = 0; m_tgt[i] = 0;
        end
        m_spec = 0;
        m_arch = 0;
    endtask

    // Model prediction for the current fetch inputs.
    task automatic m_predict(output logic pv, output logic pt,
                             output logic [31:0] tgt, output logic [31:0] idx);
        int unsigned set, i;
        bit hit;
        set = (fetch_pc >> 2) % NB;
        hit = m_bv[set] && (m_tag[set] == (fetch_pc >> (BI + 2)));
        i   = ((fetch_pc >> 2) % NP) ^ m_spec;
        pv  = fetch_valid && hit;
        pt  = pv && (m_pht[i] >= 2);
        tgt = hit ? m_tgt[set] : 32'd0;
        idx = fetch_valid ? i : 32'd0;
    endtask

    task automatic check_all(input string tag);
        logic pv, pt;
        logic [31:0] tgt, idx;
        m_predict(pv, pt, tgt, idx);
        chk({tag, ".valid"},  {31'd0, pred_valid}, {31'd0, pv});
        chk({tag, ".taken"},  {31'd0, pred_taken}, {31'd0, pt});
        chk({tag, ".target"}, pred_target, tgt);
        chk({tag, ".index"},  {24'd0, pred_index}, idx);
    endtask

    // Advance model by one clock using the inputs currently applied.
    task automatic m_clock();
        logic pv, pt;
        logic [31:0] tgt, idx;
        int unsigned arch_next, set;
        m_predict(pv, pt, tgt, idx);
        arch_next = (commit_valid && commit_pred_valid) ? ((m_arch * 2 + commit_taken) % NP) : m_arch;
        if (flush) m_spec = arch_next;
        else if (fetch_fire && pv) m_spec = (m_spec * 2 + pt) % NP;
        m_arch = arch_next;
        if (commit_valid) begin
            if (commit_taken) m_pht[commit_index] = (m_pht[commit_index] == 3) ? 3 : m_pht[commit_index] + 1;
            else              m_pht[commit_index] = (m_pht[commit_index] == 0) ? 0 : m_pht[commit_index] - 1;
        end
        if (commit_valid && commit_taken) begin
            set = (commit_pc >> 2) % NB;
            m_bv[set]  = 1'b1;
            m_tag[set] = commit_pc >> (BI + 2);
            m_tgt[set] = commit_target;
        end
    endtask

    task automatic idle();
        fetch_valid = 1'b0; fetch_fire = 1'b0; fetch_pc = 32'd0;
        commit_valid = 1'b0; commit_pred_valid = 1'b0; commit_index = 8'd0;
        commit_taken = 1'b0; commit_pc = 32'd0; commit_target = 32'd0; flush = 1'b0;
    endtask

    // Clock the DUT and the model together, then leave time for new inputs.
    task automatic step();
        m_clock();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic commit(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                          input logic [7:0] ix, input logic pvl, input logic fl);
        commit_valid = 1'b1; commit_pc = pc; commit_taken = tk; commit_target = tgt;
        commit_index = ix; commit_pred_valid = pvl; flush = fl;
    endtask

    task automatic fetch(input logic [31:0] pc, input logic fire);
        fetch_valid = 1'b1; fetch_pc = pc; fetch_fire = fire;
    endtask

    initial begin
        idle();
        m_reset();
        #1;
        rst = 1'b1;
        fetch(32'h0000_0040, 1'b0);
        #1;
        chk("reset.valid", {31'd0, pred_valid}, 32'd0);
        chk("reset.taken", {31'd0, pred_taken}, 32'd0);
        chk("reset.index", {24'd0, pred_index}, 32'h10);
        chk("reset.target", pred_target, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        idle();

        // BTB allocate + PHT train at 0x40
        commit(32'h100, 1'b1, 32'h80, 8'h40, 1'b0, 1'b0);
        fetch(32'h100, 1'b0);
        #1;
        chk("same_cycle_old.valid", {31'd0, pred_valid}, 32'd0);
        step();
        fetch(32'h100, 1'b0); #1;
        chk("alloc.valid",  {31'd0, pred_valid}, 32'd1);
        chk("alloc.target", pred_target, 32'h80);
        chk("alloc.taken",  {31'd0, pred_taken}, 32'd1);
        chk("alloc.index",  {24'd0, pred_index}, 32'h40);
        step();

        // Saturation at index 5 (pc 0x14 maps to set 5, idx 5)
        for (int k = 0; k < 4; k++) begin
            commit(32'h14, 1'b1, 32'h1000, 8'h05, 1'b0, 1'b0); step();
        end
        commit(32'h14, 1'b0, 32'h0, 8'h05, 1'b0, 1'b0); step();
        fetch(32'h14, 1'b0); #1;
        chk("sat_hi.taken",  {31'd0, pred_taken}, 32'd1);
        chk("sat_hi.target", pred_target, 32'h1000);
        step();
        for (int k = 0; k < 4; k++) begin
            commit(32'h14, 1'b0, 32'h0, 8'h05, 1'b0, 1'b0); step();
        end
        fetch(32'h14, 1'b0); #1;
        chk("sat_lo.valid", {31'd0, pred_valid}, 32'd1);
        chk("sat_lo.taken", {31'd0, pred_taken}, 32'd0);
        step();

        // Speculative history: make idx 0x41/0x43 taken, then fire 3 times
        commit(32'h100, 1'b1, 32'h80, 8'h41, 1'b0, 1'b0); step();
        commit(32'h100, 1'b1, 32'h80, 8'h43, 1'b0, 1'b0); step();
        fetch(32'h100, 1'b1); #1;
        chk("spec0.index", {24'd0, pred_index}, 32'h40);
        chk("spec0.taken", {31'd0, pred_taken}, 32'd1);
        step();
        fetch(32'h100, 1'b1); #1;
        chk("spec1.index", {24'd0, pred_index}, 32'h41);
        chk("spec1.taken", {31'd0, pred_taken}, 32'd1);
        step();
        fetch(32'h100, 1'b1); #1;
        chk("spec2.index", {24'd0, pred_index}, 32'h43);
        chk("spec2.taken", {31'd0, pred_taken}, 32'd1);
        step();
        fetch(32'h100, 1'b0); #1;
        chk("spec3.index", {24'd0, pred_index}, 32'h47);
        step();

        // Flush repair: arch=1, spec=7
        commit(32'h100, 1'b1, 32'h80, 8'h10, 1'b1, 1'b0); step();
        fetch(32'h100, 1'b0); #1;
        chk("noflush.index", {24'd0, pred_index}, 32'h47);
        step();
        commit(32'h100, 1'b0, 32'h0, 8'h20, 1'b1, 1'b1);
        fetch(32'h100, 1'b1);
        step();
        fetch(32'h100, 1'b0); #1;
        chk("flush.index", {24'd0, pred_index}, 32'h42);
        step();
        fetch(32'h100, 1'b1); #1;
        chk("flush_nt.taken", {31'd0, pred_taken}, 32'd0);
        step();
        fetch(32'h100, 1'b0); #1;
        chk("shift_nt.index", {24'd0, pred_index}, 32'h44);
        step();
        flush = 1'b1; step();
        fetch(32'h100, 1'b0); #1;
        chk("flush_only.index", {24'd0, pred_index}, 32'h42);
        step();

        // Tag alias: same set, different tag
        fetch(32'h100 + 32'd4 * NB, 1'b0); #1;
        chk("alias.valid",  {31'd0, pred_valid}, 32'd0);
        chk("alias.target", pred_target, 32'd0);
        chk("alias.index",  {24'd0, pred_index}, 32'h52);
        step();

        // No fetch_valid: index zero, target still reported on hit
        fetch_pc = 32'h100; #1;
        chk("novalid.valid",  {31'd0, pred_valid}, 32'd0);
        chk("novalid.index",  {24'd0, pred_index}, 32'd0);
        chk("novalid.target", pred_target, 32'h80);
        step();

        // Not-taken commit never invalidates
        commit(32'h100, 1'b0, 32'h0, 8'h99, 1'b0, 1'b0); step();
        fetch(32'h100, 1'b0); #1;
        chk("nt_keep.valid", {31'd0, pred_valid}, 32'd1);
        step();

        // Randomized run against the model
        for (int c = 0; c < 400; c++) begin
            fetch_valid = ($urandom_range(0, 9) != 0);
            fetch_fire  = $urandom_range(0, 1);
            fetch_pc    = $urandom_range(0, 127) << 2;
            if ($urandom_range(0, 1) == 1) begin
                commit($urandom_range(0, 127) << 2, $urandom_range(0, 1), $urandom,
                       8'($urandom_range(0, 255)), $urandom_range(0, 1),
                       ($urandom_range(0, 9) == 0));
            end else begin
                flush = ($urandom_range(0, 19) == 0);
            end
            #1;
            check_all("rand");
            step();
        end

        // Asynchronous reset mid-operation, away from any clock edge
        fetch(32'h100, 1'b0);
        #1;
        rst = 1'b1;
        #1;
        m_reset();
        chk("async_rst.valid",  {31'd0, pred_valid}, 32'd0);
        chk("async_rst.index",  {24'd0, pred_index}, 32'h40);
        chk("async_rst.target", pred_target, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        fetch(32'h14, 1'b0); #1;
        check_all("post_rst");
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
